alu_cmd_sequencer: RTL and testbench

//  Sequential front-end for the combinational BreadBoard ALU. Accepts one command
//  (op + 16-bit operand) per valid/ready handshake and keeps a 32-bit accumulator.
//  For each arithmetic command it drives the ALU operands, waits a fixed settle time
//  and captures output1/err_code. Each command produces exactly one response beat
//  on a valid/ready port.

---
 rtl/alu_cmd_sequencer.sv | 163 ++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// Sequencer around a combinational ALU: accepts one command, holds ALU operands for a settle time, returns one response.
// Latency: ALU ops raise rsp_valid on the S-th edge after accept (S = max(SETTLE_CYCLES,1)); LOAD/CLEAR/illegal on the accept edge.
// Backpressure: cmd_ready only in IDLE; the response is held stable until rsp_ready, and no new command is taken meanwhile.
module alu_cmd_sequencer #(
   parameter int SETTLE_CYCLES = 2,
   parameter int CNT_W         = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [3:0]  cmd_op,
   input  logic [15:0] cmd_operand,
   output logic [15:0] alu_input1,
   output logic [15:0] alu_input2,
   output logic [3:0]  alu_op_code,
   input  logic [31:0] alu_output1,
   input  logic [1:0]  alu_err_code,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_result,
   output logic [1:0]  rsp_err,
   output logic [31:0] acc,
   output logic [1:0]  sticky_err,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int              SETTLE_EFF = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
   localparam logic [CNT_W-1:0] CNT_START  = CNT_W'(SETTLE_EFF);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   localparam logic [3:0] OP_LAST_ALU = 4'd4;
   localparam logic [3:0] OP_LOAD     = 4'd5;
   localparam logic [3:0] OP_CLEAR    = 4'd6;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [31:0]       acc_q, acc_d;
   logic [1:0]        sticky_q, sticky_d;
   logic [31:0]       rsp_result_q, rsp_result_d;
   logic [1:0]        rsp_err_q, rsp_err_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [15:0]       alu_in1_q, alu_in1_d;
   logic [15:0]       alu_in2_q, alu_in2_d;
   logic [3:0]        alu_op_q, alu_op_d;
   logic              accept;

   assign cmd_ready = (state_q == IDLE) && !rst;
   assign accept    = cmd_valid && cmd_ready;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      acc_d        = acc_q;
      sticky_d     = sticky_q;
      rsp_result_d = rsp_result_q;
      rsp_err_d    = rsp_err_q;
      rsp_valid_d  = rsp_valid_q;
      alu_in1_d    = alu_in1_q;
      alu_in2_d    = alu_in2_q;
      alu_op_d     = alu_op_q;

      case (state_q)
         IDLE: begin
            if (accept) begin
               if (cmd_op <= OP_LAST_ALU) begin
                  // Only the low half of the accumulator reaches the ALU.
                  alu_in1_d = acc_q[15:0];
                  alu_in2_d = cmd_operand;
                  alu_op_d  = cmd_op;
                  cnt_d     = CNT_START;
                  state_d   = WAIT;
               end else if (cmd_op == OP_LOAD) begin
                  acc_d        = {{16{cmd_operand[15]}}, cmd_operand};
                  rsp_result_d = {{16{cmd_operand[15]}}, cmd_operand};
                  rsp_err_d    = 2'b00;
                  rsp_valid_d  = 1'b1;
                  state_d      = RESP;
               end else if (cmd_op == OP_CLEAR) begin
                  acc_d        = 32'd0;
                  sticky_d     = 2'b00;
                  rsp_result_d = 32'd0;
                  rsp_err_d    = 2'b00;
                  rsp_valid_d  = 1'b1;
                  state_d      = RESP;
               end else begin
                  rsp_result_d = acc_q;
                  rsp_err_d    = 2'b11;
                  rsp_valid_d  = 1'b1;
                  state_d      = RESP;
               end
            end
         end
         WAIT: begin
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
               rsp_result_d = alu_output1;
               rsp_err_d    = alu_err_code;
               sticky_d     = sticky_q | alu_err_code;
               // A divide/mod by zero result is reported but never committed.
               if (!alu_err_code[1]) begin
                  acc_d = alu_output1;
               end
               rsp_valid_d = 1'b1;
               state_d     = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d     = IDLE;
            rsp_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         acc_q        <= 32'd0;
         sticky_q     <= 2'b00;
         rsp_result_q <= 32'd0;
         rsp_err_q    <= 2'b00;
         rsp_valid_q  <= 1'b0;
         alu_in1_q    <= 16'd0;
         alu_in2_q    <= 16'd0;
         alu_op_q     <= 4'd0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         acc_q        <= acc_d;
         sticky_q     <= sticky_d;
         rsp_result_q <= rsp_result_d;
         rsp_err_q    <= rsp_err_d;
         rsp_valid_q  <= rsp_valid_d;
         alu_in1_q    <= alu_in1_d;
         alu_in2_q    <= alu_in2_d;
         alu_op_q     <= alu_op_d;
      end
   end

   assign alu_input1  = alu_in1_q;
   assign alu_input2  = alu_in2_q;
   assign alu_op_code = alu_op_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_result  = rsp_result_q;
   assign rsp_err     = rsp_err_q;
   assign acc         = acc_q;
   assign sticky_err  = sticky_q;
   assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench with a response scoreboard and a behavioural model of the ALU driven from the DUT's operand outputs.
module tb_alu_cmd_sequencer;

   logic        clk;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [3:0]  cmd_op;
   logic [15:0] cmd_operand;
   logic [15:0] alu_input1;
   logic [15:0] alu_input2;
   logic [3:0]  alu_op_code;
   logic [31:0] alu_output1;
   logic [1:0]  alu_err_code;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_result;
   logic [1:0]  rsp_err;
   logic [31:0] acc;
   logic [1:0]  sticky_err;
   logic        busy;

   int checks   = 0;
   int failures = 0;
   logic [33:0] exp_q[$];

   alu_cmd_sequencer #(.SETTLE_CYCLES(2), .CNT_W(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_op       (cmd_op),
      .cmd_operand  (cmd_operand),
      .alu_input1   (alu_input1),
      .alu_input2   (alu_input2),
      .alu_op_code  (alu_op_code),
      .alu_output1  (alu_output1),
      .alu_err_code (alu_err_code),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_result   (rsp_result),
      .rsp_err      (rsp_err),
      .acc          (acc),
      .sticky_err   (sticky_err),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Combinational ALU: zero-extended 16-bit operands, divide/mod by zero flags bit1.
   always_comb begin
      alu_output1  = 32'd0;
      alu_err_code = 2'b00;
      case (alu_op_code)
         4'd0: alu_output1 = {16'd0, alu_input1} + {16'd0, alu_input2};
         4'd1: alu_output1 = {16'd0, alu_input1} - {16'd0, alu_input2};
         4'd2: alu_output1 = {16'd0, alu_input1} * {16'd0, alu_input2};
         4'd3: if (alu_input2 == 16'd0) alu_err_code = 2'b10;
               else alu_output1 = {16'd0, alu_input1 / alu_input2};
         4'd4: if (alu_input2 == 16'd0) alu_err_code = 2'b10;
               else alu_output1 = {16'd0, alu_input1 % alu_input2};
         default: alu_output1 = 32'd0;
      endcase
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: every completed response handshake is matched against the oldest expectation.
   always @(negedge clk) begin
      if (rsp_valid && rsp_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL rsp_unexpected actual=%h/%b required=none", rsp_result, rsp_err);
         end else begin
            logic [33:0] e;
            e = exp_q.pop_front();
            if ({rsp_result, rsp_err} !== e) begin
               failures++;
               $display("FAIL rsp actual=%h/%b required=%h/%b", rsp_result, rsp_err, e[33:2], e[1:0]);
            end
         end
      end
   end

   // Present a command from a negedge, wait for cmd_ready, and return at the first negedge after the accept edge.
   task automatic send(input logic [3:0] op, input logic [15:0] operand, input logic [33:0] exp, input bit expect_rsp);
      int n;
      @(negedge clk);
      cmd_valid   = 1'b1;
      cmd_op      = op;
      cmd_operand = operand;
      n = 0;
      while (!cmd_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_ready) begin
         chk("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
      end
      if (expect_rsp) exp_q.push_back(exp);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      @(negedge clk);
   endtask

   // Extra edges after the accept edge until rsp_valid is seen high.
   task automatic wait_rsp(input string name, input int exp_lat);
      int lat;
      lat = 0;
      while (!rsp_valid && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      chk(name, 32'(lat), 32'(exp_lat));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst         = 1'b1;
      cmd_valid   = 1'b1;
      cmd_op      = 4'd5;
      cmd_operand = 16'h1234;
      rsp_ready   = 1'b1;

      // Reset with a command pending: nothing accepted, everything zero.
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
         chk("rst_acc", acc, 32'd0);
         chk("rst_outs", {alu_input1, alu_input2}, 32'd0);
         chk("rst_misc", {22'd0, alu_op_code, rsp_valid, rsp_err, sticky_err, busy}, 32'd0);
         chk("rst_rsp_result", rsp_result, 32'd0);
      end
      cmd_valid = 1'b0;
      rst       = 1'b0;
      #1;
      chk("rel_cmd_ready", 32'(cmd_ready), 32'd1);
      @(negedge clk);
      chk("rel_acc", acc, 32'd0);

      // LOAD then MUL.
      send(4'd5, 16'd11, {32'd11, 2'b00}, 1'b1);
      wait_rsp("lat_load", 0);
      chk("acc_load", acc, 32'd11);
      send(4'd2, 16'd15, {32'd165, 2'b00}, 1'b1);
      chk("mul_in1", {16'd0, alu_input1}, 32'd11);
      chk("mul_in2", {16'd0, alu_input2}, 32'd15);
      chk("mul_op", {28'd0, alu_op_code}, 32'd2);
      chk("mul_busy", 32'(busy), 32'd1);
      wait_rsp("lat_mul", 2);
      chk("acc_mul", acc, 32'd165);

      // Divide by zero keeps acc and sets sticky; CLEAR wipes both.
      send(4'd3, 16'd0, {32'd0, 2'b10}, 1'b1);
      wait_rsp("lat_div0", 2);
      chk("acc_div0", acc, 32'd165);
      chk("sticky_div0", {30'd0, sticky_err}, 32'd2);
      send(4'd6, 16'h00AA, {32'd0, 2'b00}, 1'b1);
      wait_rsp("lat_clear", 0);
      chk("acc_clear", acc, 32'd0);
      chk("sticky_clear", {30'd0, sticky_err}, 32'd0);

      // Response stalled for 5 cycles.
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      send(4'd5, 16'd7, {32'd7, 2'b00}, 1'b1);
      for (int i = 0; i < 5; i++) begin
         chk("stall_valid", 32'(rsp_valid), 32'd1);
         chk("stall_result", rsp_result, 32'd7);
         chk("stall_ready_busy", {30'd0, cmd_ready, busy}, 32'd1);
         @(negedge clk);
      end
      @(posedge clk);
      #1 rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("stall_release_ready", 32'(cmd_ready), 32'd1);
      chk("stall_release_valid", 32'(rsp_valid), 32'd0);

      // Modulo by zero, then illegal op leaves acc/sticky alone, then sign-extending LOAD.
      send(4'd4, 16'd0, {32'd0, 2'b10}, 1'b1);
      wait_rsp("lat_mod0", 2);
      chk("acc_mod0", acc, 32'd7);
      send(4'd9, 16'd3, {32'd7, 2'b11}, 1'b1);
      wait_rsp("lat_illegal", 0);
      chk("acc_illegal", acc, 32'd7);
      chk("sticky_illegal", {30'd0, sticky_err}, 32'd2);
      send(4'd5, 16'hFFFE, {32'hFFFF_FFFE, 2'b00}, 1'b1);
      wait_rsp("lat_load_neg", 0);
      chk("acc_load_neg", acc, 32'hFFFF_FFFE);

      // Only acc[15:0] feeds the ALU.
      send(4'd0, 16'd3, {32'h0001_0001, 2'b00}, 1'b1);
      chk("add_in1_trunc", {16'd0, alu_input1}, 32'h0000_FFFE);
      wait_rsp("lat_add", 2);
      chk("acc_add", acc, 32'h0001_0001);

      // Reset during WAIT discards the command.
      send(4'd2, 16'd2, 34'd0, 1'b0);
      chk("wait_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_acc", acc, 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_sticky", {30'd0, sticky_err}, 32'd0);
      for (int i = 0; i < 5; i++) begin
         chk("midrst_no_rsp", 32'(rsp_valid), 32'd0);
         @(negedge clk);
      end

      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
